// File: rtl/sram_port_arbiter.sv
// ---------------------------------------------------------------------------
// sram_port_arbiter
//
// Shares the split 64-bit SRAM (lower-word bank + upper-word bank, one common
// address) between the calculator controller ("calc") and the host
// load/readback port ("host").
//
// Per cycle at most one request is accepted (req && gnt). Single requests win
// outright. When both compete, the winner is picked round-robin, unless the
// host holds a burst lock. Under lock the host keeps winning for LOCK_MAX
// accepts, then calc gets one slot, and the cycle repeats.
//
// Read data comes back RD_LAT cycles after the accept. It is registered into
// the owning requester's rdata, so rvalid is seen at t+RD_LAT+1.
//
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   calc_req/we/addr/wdata       calc request side
//   calc_gnt                     calc accepted this cycle (combinational)
//   calc_rvalid/rdata            calc read return (registered)
//   host_req/we/lock/addr/wdata  host request side, lock requests a burst
//   host_gnt                     host accepted this cycle (combinational)
//   host_rvalid/rdata            host read return (registered)
//   sram_cs/we/addr              SRAM strobe, write enable and address
//   sram_wdata_lo/hi             wdata[31:0] / wdata[63:32]
//   sram_rdata_lo/hi             bank read data, valid RD_LAT after the accept
//   calc_grant_cnt               saturating count of calc accepts
//   host_grant_cnt               saturating count of host accepts
//   contention_cnt               saturating count of cycles with both req high
// ---------------------------------------------------------------------------
module sram_port_arbiter #(
    parameter int ADDR_W   = 10,
    parameter int RD_LAT   = 1,
    parameter int LOCK_MAX = 8,
    parameter int CNT_W    = 32
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              calc_req,
    input  logic              calc_we,
    input  logic [ADDR_W-1:0] calc_addr,
    input  logic [63:0]       calc_wdata,
    output logic              calc_gnt,
    output logic              calc_rvalid,
    output logic [63:0]       calc_rdata,

    input  logic              host_req,
    input  logic              host_we,
    input  logic              host_lock,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [63:0]       host_wdata,
    output logic              host_gnt,
    output logic              host_rvalid,
    output logic [63:0]       host_rdata,

    output logic              sram_cs,
    output logic              sram_we,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [31:0]       sram_wdata_lo,
    output logic [31:0]       sram_wdata_hi,
    input  logic [31:0]       sram_rdata_lo,
    input  logic [31:0]       sram_rdata_hi,

    output logic [CNT_W-1:0]  calc_grant_cnt,
    output logic [CNT_W-1:0]  host_grant_cnt,
    output logic [CNT_W-1:0]  contention_cnt
);

    localparam int  LC_W     = $clog2(LOCK_MAX + 1);
    localparam logic OWN_CALC = 1'b0;
    localparam logic OWN_HOST = 1'b1;

    typedef enum logic {
        LOCK_IDLE,
        LOCK_HELD
    } lock_state_t;

    lock_state_t       lock_state_reg, lock_state_next;
    logic [LC_W-1:0]   lock_cnt_reg, lock_cnt_next;
    logic              last_gnt_reg;

    logic              both_req;
    logic              lock_hold;
    logic              accept;
    logic              accept_owner;

    logic [RD_LAT-1:0] tag_valid_reg;
    logic [RD_LAT-1:0] tag_owner_reg;

    logic              calc_rvalid_reg, host_rvalid_reg;
    logic [63:0]       calc_rdata_reg, host_rdata_reg;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    assign both_req = calc_req && host_req;

    // The lock only counts while the host is still asking for it; dropping
    // host_lock or host_req hands control back to round-robin in that same
    // cycle, ahead of the registered state clearing.
    assign lock_hold = (lock_state_reg == LOCK_HELD) && host_lock && host_req;

    always_comb begin
        calc_gnt = 1'b0;
        host_gnt = 1'b0;
        if (!rst) begin
            if (calc_req && !host_req) begin
                calc_gnt = 1'b1;
            end else if (host_req && !calc_req) begin
                host_gnt = 1'b1;
            end else if (both_req) begin
                if (lock_hold) begin
                    // Host keeps the port until LOCK_MAX accepts, then calc
                    // is given exactly one slot.
                    if (lock_cnt_reg < LC_W'(LOCK_MAX)) begin
                        host_gnt = 1'b1;
                    end else begin
                        calc_gnt = 1'b1;
                    end
                end else if (last_gnt_reg == OWN_HOST) begin
                    calc_gnt = 1'b1;
                end else begin
                    host_gnt = 1'b1;
                end
            end
        end
    end

    assign accept       = calc_gnt || host_gnt;
    assign accept_owner = host_gnt ? OWN_HOST : OWN_CALC;

    // ------------------------------------------------------------------
    // SRAM drive: winner's fields pass through, everything zero when idle
    // ------------------------------------------------------------------
    always_comb begin
        sram_cs       = 1'b0;
        sram_we       = 1'b0;
        sram_addr     = '0;
        sram_wdata_lo = '0;
        sram_wdata_hi = '0;
        if (calc_gnt) begin
            sram_cs       = 1'b1;
            sram_we       = calc_we;
            sram_addr     = calc_addr;
            sram_wdata_lo = calc_wdata[31:0];
            sram_wdata_hi = calc_wdata[63:32];
        end else if (host_gnt) begin
            sram_cs       = 1'b1;
            sram_we       = host_we;
            sram_addr     = host_addr;
            sram_wdata_lo = host_wdata[31:0];
            sram_wdata_hi = host_wdata[63:32];
        end
    end

    // ------------------------------------------------------------------
    // Lock state machine
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            lock_state_reg <= LOCK_IDLE;
            lock_cnt_reg   <= '0;
        end else begin
            lock_state_reg <= lock_state_next;
            lock_cnt_reg   <= lock_cnt_next;
        end
    end

    always_comb begin
        lock_state_next = lock_state_reg;
        lock_cnt_next   = lock_cnt_reg;
        if (!(host_lock && host_req)) begin
            lock_state_next = LOCK_IDLE;
            lock_cnt_next   = '0;
        end else begin
            if (host_gnt && (lock_state_reg == LOCK_IDLE)) begin
                lock_state_next = LOCK_HELD;
            end
            // Only accepts made while calc is actually waiting use up the
            // burst budget.
            if (lock_hold && calc_req) begin
                if (host_gnt) begin
                    lock_cnt_next = lock_cnt_reg + 1'b1;
                end else if (calc_gnt) begin
                    lock_cnt_next = '0;
                end
            end
        end
    end

    // Reset to HOST so calc wins the first contended cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_gnt_reg <= OWN_HOST;
        end else if (accept) begin
            last_gnt_reg <= accept_owner;
        end
    end

    // ------------------------------------------------------------------
    // Read tag pipeline: stage RD_LAT-1 lines up with the cycle in which the
    // SRAM presents the data for that access.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_valid_reg <= '0;
            tag_owner_reg <= '0;
        end else begin
            tag_valid_reg[0] <= accept && !sram_we;
            tag_owner_reg[0] <= accept_owner;
            for (int i = 1; i < RD_LAT; i++) begin
                tag_valid_reg[i] <= tag_valid_reg[i-1];
                tag_owner_reg[i] <= tag_owner_reg[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            calc_rvalid_reg <= 1'b0;
            host_rvalid_reg <= 1'b0;
            calc_rdata_reg  <= '0;
            host_rdata_reg  <= '0;
        end else begin
            calc_rvalid_reg <= 1'b0;
            host_rvalid_reg <= 1'b0;
            if (tag_valid_reg[RD_LAT-1]) begin
                if (tag_owner_reg[RD_LAT-1] == OWN_HOST) begin
                    host_rvalid_reg <= 1'b1;
                    host_rdata_reg  <= {sram_rdata_hi, sram_rdata_lo};
                end else begin
                    calc_rvalid_reg <= 1'b1;
                    calc_rdata_reg  <= {sram_rdata_hi, sram_rdata_lo};
                end
            end
        end
    end

    assign calc_rvalid = calc_rvalid_reg;
    assign calc_rdata  = calc_rdata_reg;
    assign host_rvalid = host_rvalid_reg;
    assign host_rdata  = host_rdata_reg;

    // ------------------------------------------------------------------
    // Saturating performance counters: 0 = calc grants, 1 = host grants,
    // 2 = contention cycles.
    // ------------------------------------------------------------------
    logic [2:0] cnt_inc;
    assign cnt_inc = {both_req, host_gnt, calc_gnt};

    for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
        logic [CNT_W-1:0] count_reg;
        always_ff @(posedge clk) begin
            if (rst) begin
                count_reg <= '0;
            end else if (cnt_inc[gi] && (count_reg != {CNT_W{1'b1}})) begin
                count_reg <= count_reg + 1'b1;
            end
        end
    end

    assign calc_grant_cnt = g_cnt[0].count_reg;
    assign host_grant_cnt = g_cnt[1].count_reg;
    assign contention_cnt = g_cnt[2].count_reg;

endmodule
